// File: rtl/onehot_req_arbiter.sv
// onehot_req_arbiter: four-source round-robin arbiter that drives the one-hot
// inputs x0..x3 of a downstream 4x2 encoder. A request is recognised on a
// rising level of its (optionally filtered) request line. The request is held
// pending until its grant is acknowledged.
// Optional feature macro: DEBOUNCE_EN adds a 2-flop synchronizer and a
// DB_CYCLES-sample stability filter in front of the edge detector.
module onehot_req_arbiter #(
    parameter int DB_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       ack,
    output logic       x0,
    output logic       x1,
    output logic       x2,
    output logic       x3,
    output logic       valid,
    output logic [3:0] pend
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Request levels after optional filtering; these feed the edge detector.
    logic [3:0] filt_s;

    // A filter length below one sample is meaningless; this block only keeps
    // the parameter referenced in builds without the filter.
    if (DB_CYCLES < 1) begin : g_db_cycles_invalid
    end

`ifdef DEBOUNCE_EN
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [3:0]    sync1_r;
    logic [3:0]    sync2_r;
    logic [3:0]    filt_r;
    logic [CW-1:0] cnt_r [4];

    // Synchronize raw requests and change a filtered level only after
    // DB_CYCLES consecutive synchronized samples disagree with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 4'b1111;
            sync2_r <= 4'b1111;
            filt_r  <= 4'b1111;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
        end else begin
            sync1_r <= req;
            sync2_r <= sync1_r;
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] == filt_r[i]) begin
                    cnt_r[i] <= {CW{1'b0}};
                end else if (cnt_r[i] == CW'(DB_CYCLES - 1)) begin
                    filt_r[i] <= sync2_r[i];
                    cnt_r[i]  <= {CW{1'b0}};
                end else begin
                    cnt_r[i] <= cnt_r[i] + CW'(1);
                end
            end
        end
    end

    assign filt_s = filt_r;
`else
    assign filt_s = req;
`endif

    state_t     state_r;
    logic [3:0] req_q_r;
    logic [3:0] pend_r;
    logic [3:0] x_r;
    logic       valid_r;
    logic [1:0] ptr_r;
    logic [1:0] gidx_r;

    logic [3:0] event_s;
    logic [3:0] clr_s;
    logic [3:0] pend_nxt_s;
    logic [1:0] pick_s;

    // First set bit of vec, searching upward from start and wrapping 3 -> 0.
    // Iterating from the farthest offset down leaves the nearest hit last.
    function automatic logic [1:0] first_from(input logic [3:0] vec,
                                              input logic [1:0] start);
        logic [1:0] res;
        logic [1:0] idx;
        res = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (vec[idx]) begin
                res = idx;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Rising-edge detection, grant selection and pending-flag update; a new
    // event on the bit being acknowledged re-sets it (set wins over clear).
    always_comb begin
        event_s = filt_s & ~req_q_r;
        pick_s  = first_from(pend_r, ptr_r);
        clr_s   = 4'b0000;
        if ((state_r == GRANT) && ack) begin
            clr_s = 4'b0001 << gidx_r;
        end else begin
            clr_s = 4'b0000;
        end
        pend_nxt_s = (pend_r & ~clr_s) | event_s;
    end

    // Grant FSM with registered one-hot grant lines, valid and pending flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            req_q_r <= 4'b1111;
            pend_r  <= 4'b0000;
            x_r     <= 4'b0000;
            valid_r <= 1'b0;
            ptr_r   <= 2'd0;
            gidx_r  <= 2'd0;
        end else begin
            req_q_r <= filt_s;
            pend_r  <= pend_nxt_s;
            case (state_r)
                IDLE: begin
                    if (pend_r != 4'b0000) begin
                        state_r <= GRANT;
                        gidx_r  <= pick_s;
                        x_r     <= 4'b0001 << pick_s;
                        valid_r <= 1'b1;
                    end else begin
                        x_r     <= 4'b0000;
                        valid_r <= 1'b0;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        state_r <= IDLE;
                        x_r     <= 4'b0000;
                        valid_r <= 1'b0;
                        ptr_r   <= gidx_r + 2'd1;
                    end else begin
                        state_r <= GRANT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    x_r     <= 4'b0000;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign x0    = x_r[0];
    assign x1    = x_r[1];
    assign x2    = x_r[2];
    assign x3    = x_r[3];
    assign valid = valid_r;
    assign pend  = pend_r;

endmodule

// File: doc/onehot_req_arbiter.md
ONEHOT_REQ_ARBITER -- requirements
Module: onehot_req_arbiter

Interface
REQ-001 Parameter DB_CYCLES, default 8, number of consecutive stable samples a request must hold before its filtered level changes; used only when DEBOUNCE_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req  input  4  raw level request lines, bit i = source i.
REQ-005 ack  input  1  downstream (4x2 encoder consumer) accepts the current grant.
REQ-006 x0, x1, x2, x3  output  1 each  registered one-hot grant lines, driving encoder inputs x0..x3 directly.
REQ-007 valid  output  1  high while exactly one of x0..x3 is high.
REQ-008 pend  output  4  registered pending-event flags, bit i = source i awaiting grant.

Function
REQ-009 The block SHALL detect a request event on bit i when filtered req[i] is 1 and its previous-cycle registered copy req_q[i] is 0.
REQ-010 An event SHALL set pend[i] on the same rising edge that samples it.
REQ-011 An event on a bit whose pend is already 1 SHALL be absorbed with no count kept.
REQ-012 The FSM SHALL have two states: IDLE (x0..x3 = 0, valid = 0) and GRANT (one x line high, valid = 1).
REQ-013 In IDLE with pend != 0, the next edge SHALL enter GRANT and assert the first set pend bit searching upward from ptr, wrapping 3->0.
REQ-014 Minimum latency: req rising, sampled at edge k -> pend set at edge k -> x/valid high after edge k+1.
REQ-015 In GRANT, x0..x3 and valid SHALL hold unchanged until ack is sampled 1.
REQ-016 On an edge where ack = 1 in GRANT: clear the granted pend bit, set ptr = granted index + 1 mod 4, return to IDLE.
REQ-017 At least one IDLE cycle SHALL separate consecutive grants.
REQ-018 ack sampled in IDLE SHALL be ignored.
REQ-019 When a new event on the granted bit coincides with its ack clear, set SHALL win and pend[i] SHALL remain 1.
REQ-020 Events on other bits during GRANT SHALL set their pend bits without disturbing the current grant.
REQ-021 x0..x3 SHALL never have more than one bit high in any cycle.

Reset
REQ-022 With rst_n = 0 at an edge: state = IDLE, x0..x3 = 0, valid = 0, pend = 0, ptr = 0, req_q = 4'b1111.
REQ-023 Requests held high through reset deassertion SHALL NOT generate events until they fall and rise again.
REQ-024 Reset asserted during GRANT SHALL drop the grant at that edge with no pend retained.
REQ-025 With DEBOUNCE_EN defined, reset SHALL clear synchronizer flops, counters and filtered levels to 1.

Configuration
REQ-026 Macro DEBOUNCE_EN, defined: each req bit passes a 2-flop synchronizer, then a counter; the filtered level changes only after DB_CYCLES consecutive samples differ from it. Counter resets on any sample equal to the filtered level. Added latency: 2 + DB_CYCLES cycles.
REQ-027 Macro DEBOUNCE_EN, undefined: req feeds the edge detector directly, DB_CYCLES unused, latency per REQ-014.

Verification
REQ-028 Reset release, then req=0001 for 1 cycle -> x0=1, valid=1 two edges after the rise; ack=1 for one cycle -> pend=0000, valid=0.
REQ-029 req 0000->1111 in one cycle, ack held 1 -> grant order x0,x1,x2,x3, each 1 cycle with 1 IDLE cycle between; pend=0000 at end.
REQ-030 ptr=2 (after a grant of source 1), pend=1001 -> x3 granted before x0.
REQ-031 Grant x1 active, ack=0 for 5 cycles, req[2] pulses -> x1 held 5 cycles, pend=0110; after ack, x2 granted next.
REQ-032 req[0] rises on the same edge x0 is acked -> pend[0] stays 1 and x0 is re-granted after one IDLE cycle.
REQ-033 DEBOUNCE_EN, DB_CYCLES=8: a 5-cycle glitch on req[3] -> no pend change; a 20-cycle pulse -> pend[3]=1 exactly 10 cycles after the rise.
